// File: rtl/full_adder_pkg.sv
// Shared types and constants for the registered ripple-carry adder.
// Optional FULL_ADDER_UNIT_OVERFLOW_EN adds a signed-overflow output on the top level.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  // Widest possible result bundle; narrower instances use the low sum bits.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic                 overflow;
  } fa_result_t;

  localparam logic [MAX_WIDTH-1:0] RESET_SUM = '0;

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full adder cell, purely combinational.
// Zero latency; no flow control.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry adder: 1-cycle latency, accepts every cycle, no backpressure.
// FULL_ADDER_UNIT_OVERFLOW_EN adds a registered two's-complement overflow flag.
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputCarry,
  input  logic             InputValid,
  output logic [WIDTH-1:0] OutputS,
  output logic             OutputCarry,
  output logic             OutputValid
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  ,
  output logic             OutputOverflow
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder_unit: WIDTH out of range");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = InputCarry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (InputA[i]),
      .b    (InputB[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             valid_d, valid_q;

  // Idle cycles hold the result, so unknown operands never reach the flops.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = InputValid;
    if (InputValid) begin
      sum_d   = s;
      carry_d = c[WIDTH];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sum_q   <= RESET_SUM[WIDTH-1:0];
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign OutputS     = sum_q;
  assign OutputCarry = carry_q;
  assign OutputValid = valid_q;

`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (InputValid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OutputOverflow = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit: WIDTH=1 and WIDTH=8 instances against an arithmetic reference.
`timescale 1ns/1ps
module tb_full_adder_unit;
  import full_adder_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       cin, vld;

  logic       s1, c1, v1;
  logic [7:0] s8;
  logic       c8, v8;
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  logic       o1, o8;
`endif

  int checks = 0;
  int errors = 0;

  always #10 Clock = ~Clock;

  full_adder_unit #(.WIDTH(1)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .InputA(a1), .InputB(b1),
    .InputCarry(cin), .InputValid(vld),
    .OutputS(s1), .OutputCarry(c1), .OutputValid(v1)
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    , .OutputOverflow(o1)
`endif
  );

  full_adder_unit #(.WIDTH(8)) dut8 (
    .Clock(Clock), .Reset_n(Reset_n), .InputA(a8), .InputB(b8),
    .InputCarry(cin), .InputValid(vld),
    .OutputS(s8), .OutputCarry(c8), .OutputValid(v8)
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    , .OutputOverflow(o8)
`endif
  );

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic fa_result_t ref_add(input longint a, input longint b, input longint c, input int w);
    fa_result_t r;
    longint tot, sa, sb, ss, half;
    half = longint'(1) << (w - 1);
    tot  = a + b + c;
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    ss   = sa + sb + c;
    r          = '0;
    r.sum      = MAX_WIDTH'(tot % (2 * half));
    r.carry    = (tot >= 2 * half);
    r.overflow = (ss > half - 1) || (ss < -half);
    return r;
  endfunction

  fa_result_t m1, m8;
  logic       mv;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m1 <= '0;
      m8 <= '0;
      mv <= 1'b0;
    end else begin
      mv <= vld;
      if (vld) begin
        m1 <= ref_add(longint'(a1), longint'(b1), longint'(cin), 1);
        m8 <= ref_add(longint'(a8), longint'(b8), longint'(cin), 8);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    #2;
    chk("s1", 64'(s1), 64'(m1.sum[0]));
    chk("c1", 64'(c1), 64'(m1.carry));
    chk("v1", 64'(v1), 64'(mv));
    chk("s8", 64'(s8), 64'(m8.sum[7:0]));
    chk("c8", 64'(c8), 64'(m8.carry));
    chk("v8", 64'(v8), 64'(mv));
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    chk("o1", 64'(o1), 64'(m1.overflow));
    chk("o8", 64'(o8), 64'(m8.overflow));
`endif
  end

  task automatic drive_rand(input logic valid);
    a1  = 1'($urandom);
    b1  = 1'($urandom);
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    cin = 1'($urandom);
    vld = valid;
  endtask

  logic [7:0] tt_s, tt_c, tt_o;

  initial begin
    tt_s = 8'b1001_0110;  // index i = {Cin,B,A}
    tt_c = 8'b1110_1000;
    tt_o = 8'b0001_1000;
    Reset_n = 1'b0;
    drive_rand(1'b1);

    // Reset held with live valid operands
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      drive_rand(1'b1);
      chk("rst_s8", 64'(s8), 64'h0);
      chk("rst_v8", 64'(v8), 64'h0);
    end
    @(negedge Clock);
    Reset_n = 1'b1;

    // WIDTH=1 truth table, hand-computed expectations
    for (int i = 0; i < 8; i++) begin
      a1 = i[0]; b1 = i[1]; cin = i[2]; vld = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge Clock);
      #3;
      chk($sformatf("tt_s%0d", i), 64'(s1), 64'(tt_s[i]));
      chk($sformatf("tt_c%0d", i), 64'(c1), 64'(tt_c[i]));
      chk($sformatf("tt_v%0d", i), 64'(v1), 64'h1);
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
      chk($sformatf("tt_o%0d", i), 64'(o1), 64'(tt_o[i]));
`endif
      @(negedge Clock);
    end

    // Hold: 1+1 valid, then idle with zero / unknown operands
    a1 = 1'b1; b1 = 1'b1; cin = 1'b0; vld = 1'b1;
    @(negedge Clock);
    a1 = 1'b0; b1 = 1'b0; vld = 1'b0;
    a8 = 'x; b8 = 'x; cin = 1'bx;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock);
      #3;
      chk("hold_s", 64'(s1), 64'h0);
      chk("hold_c", 64'(c1), 64'h1);
      chk("hold_v", 64'(v1), 64'h0);
    end
    @(negedge Clock);

    // WIDTH=8 wrap and overflow corners
    a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1; vld = 1'b1;
    @(posedge Clock);
    #3;
    chk("wrap_s", 64'(s8), 64'hFF);
    chk("wrap_c", 64'(c8), 64'h1);
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    chk("wrap_o", 64'(o8), 64'h0);
`endif
    @(negedge Clock);
    a8 = 8'h80; b8 = 8'h80; cin = 1'b0;
    @(posedge Clock);
    #3;
    chk("ovf_s", 64'(s8), 64'h00);
    chk("ovf_c", 64'(c8), 64'h1);
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    chk("ovf_o", 64'(o8), 64'h1);
`endif
    @(negedge Clock);

    // Throughput: 100 back-to-back valid operands
    for (int i = 0; i < 100; i++) begin
      drive_rand(1'b1);
      @(negedge Clock);
    end

    // Mid-stream asynchronous reset between edges
    drive_rand(1'b1);
    @(posedge Clock);
    #5;
    Reset_n = 1'b0;
    #1;
    chk("arst_s8", 64'(s8), 64'h0);
    chk("arst_c8", 64'(c8), 64'h0);
    chk("arst_v8", 64'(v8), 64'h0);
    @(negedge Clock);
    drive_rand(1'b1);
    @(negedge Clock);
    Reset_n = 1'b1;
    a8 = 8'h3C; b8 = 8'h5A; cin = 1'b1; vld = 1'b1;
    @(posedge Clock);
    #3;
    chk("post_s8", 64'(s8), 64'h97);
    chk("post_c8", 64'(c8), 64'h0);
    chk("post_v8", 64'(v8), 64'h1);
    @(negedge Clock);

    // Random mix of valid and idle cycles
    for (int i = 0; i < 200; i++) begin
      drive_rand(1'($urandom));
      @(negedge Clock);
    end

    vld = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
